// File: rtl/sonic_addr_pkg.sv
// Shared constants and types for the sonic address sequencer slice.
package sonic_addr_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned CNT_W  = 14;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } seq_state_e;

endpackage

// File: rtl/sonic_addr_wrap_counter.sv
// Registered ring address with load and wrap-to-0 increment.
// Optional SONIC_ADDR_SEQ_PARITY_EN adds a registered even-parity bit.
module sonic_addr_wrap_counter #(
  parameter int unsigned ADDR_W = sonic_addr_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] addr
`ifdef SONIC_ADDR_SEQ_PARITY_EN
  ,
  output logic              addr_par
`endif
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_val;
    end else if (inc) begin
      addr_d = (addr_q == last) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

`ifdef SONIC_ADDR_SEQ_PARITY_EN
  logic par_q;

  // Parity tracks addr_d every cycle, so it stays in lockstep with addr_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^addr_d;
    end
  end

  assign addr_par = par_q;
`endif

endmodule

// File: rtl/sonic_address_sequencer.sv
// Ring address generator feeding sonic_address_converter over valid/ready.
// Optional SONIC_ADDR_SEQ_PARITY_EN adds addr_par / par_err_inject.
module sonic_address_sequencer #(
  parameter int unsigned ADDR_W = sonic_addr_pkg::ADDR_W,
  parameter int unsigned CNT_W  = sonic_addr_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_last,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_cnt
`ifdef SONIC_ADDR_SEQ_PARITY_EN
  ,
  output logic              addr_par,
  input  logic              par_err_inject
`endif
);

  import sonic_addr_pkg::*;

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              done_q, done_d;
  logic              load, inc, hs;

  // Valid is exactly "in RUN": it rises on start and falls only on the final beat or abort.
  assign addr_valid = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign sent_cnt   = cnt_q;
  assign hs         = addr_valid && addr_ready;
  assign cnt_inc    = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load    = 1'b0;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            load    = 1'b1;
            len_d   = cfg_len;
            last_d  = cfg_last;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            inc = 1'b1;
          end
        end
        if (abort) begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

`ifdef SONIC_ADDR_SEQ_PARITY_EN
  logic par_raw;

  sonic_addr_wrap_counter #(
    .ADDR_W(ADDR_W)
  ) u_wrap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .inc      (inc),
    .load_val (cfg_base),
    .last     (last_q),
    .addr     (addr_out),
    .addr_par (par_raw)
  );

  assign addr_par = par_raw ^ par_err_inject;
`else
  sonic_addr_wrap_counter #(
    .ADDR_W(ADDR_W)
  ) u_wrap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .inc      (inc),
    .load_val (cfg_base),
    .last     (last_q),
    .addr     (addr_out)
  );
`endif

endmodule

// File: tb/tb_sonic_address_sequencer.sv
// Randomized self-checking bench for sonic_address_sequencer against a queue-based model.
module tb_sonic_address_sequencer;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned CNT_W  = 14;
  localparam int          RING   = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W-1:0] cfg_last;
  logic [CNT_W-1:0]  cfg_len;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid;
  logic              addr_ready;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  sent_cnt;
`ifdef SONIC_ADDR_SEQ_PARITY_EN
  logic              addr_par;
  logic              par_err_inject;
`endif

  int checks   = 0;
  int failures = 0;
  int m_sent   = 0;

  sonic_address_sequencer #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_base   (cfg_base),
    .cfg_last   (cfg_last),
    .cfg_len    (cfg_len),
    .start      (start),
    .abort      (abort),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .busy       (busy),
    .done       (done),
    .sent_cnt   (sent_cnt)
`ifdef SONIC_ADDR_SEQ_PARITY_EN
    ,
    .addr_par       (addr_par),
    .par_err_inject (par_err_inject)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_addr"},  addr_out,   0);
    check({tag, "_valid"}, addr_valid, 0);
    check({tag, "_busy"},  busy,       0);
    check({tag, "_done"},  done,       0);
    check({tag, "_sent"},  sent_cnt,   0);
  endtask

  // mode: 0 ready high, 1 random ready, 2 fixed pattern, 3 high except on the abort cycle
  task automatic run_seq(input int base, input int last, input int len, input int mode,
                         input int abort_at, input int rst_at);
    int  exp_q[$];
    int  a, acc;
    int  pat[6];
    bit  fin;
    pat = '{0, 0, 1, 0, 1, 1};
    a = base;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(a);
      a = (a == last) ? 0 : (a + 1) % RING;
    end

    @(negedge clk);
    cfg_base = ADDR_W'(base);
    cfg_last = ADDR_W'(last);
    cfg_len  = CNT_W'(len);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cfg_base = ADDR_W'($urandom);
    cfg_last = ADDR_W'($urandom);
    cfg_len  = CNT_W'($urandom);

    if (len == 0) begin
      check("zl_done",  done,       1);
      check("zl_valid", addr_valid, 0);
      check("zl_busy",  busy,       0);
      check("zl_sent",  sent_cnt,   m_sent);
      @(negedge clk);
      check("zl_done_clr", done,       0);
      check("zl_valid2",   addr_valid, 0);
      return;
    end

    check("start_busy", busy,     1);
    check("start_sent", sent_cnt, 0);
    acc = 0;
    fin = 1'b0;
    for (int cyc = 0; cyc < len * 4 + 64 && !fin; cyc++) begin
      check("valid",    addr_valid, 1);
      check("busy",     busy,       1);
      check("done_low", done,       0);
      check("sent",     sent_cnt,   acc);
      check("addr",     addr_out,   exp_q[acc]);
`ifdef SONIC_ADDR_SEQ_PARITY_EN
      check("par", addr_par, (^exp_q[acc][ADDR_W-1:0]) ^ par_err_inject);
      par_err_inject = 1'($urandom_range(0, 1));
`endif
      if (rst_at >= 0 && acc == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check_idle_zero("rst_async");
        @(negedge clk);
        check_idle_zero("rst_hold");
        rst_n      = 1'b1;
        addr_ready = 1'b0;
        m_sent     = 0;
        return;
      end
      abort = (abort_at >= 0 && acc == abort_at);
      case (mode)
        0:       addr_ready = 1'b1;
        1:       addr_ready = 1'($urandom_range(0, 1));
        2:       addr_ready = (cyc < 6) ? 1'(pat[cyc]) : 1'b1;
        default: addr_ready = !abort;
      endcase
      if (mode == 1 && $urandom_range(0, 7) == 0) begin
        start    = 1'b1;
        cfg_base = ADDR_W'($urandom);
        cfg_len  = CNT_W'($urandom_range(0, 20));
      end else begin
        start = 1'b0;
      end
      if (addr_ready) acc++;
      if (acc == len || abort) fin = 1'b1;
      @(negedge clk);
    end
    start      = 1'b0;
    abort      = 1'b0;
    addr_ready = 1'b0;
    check("timeout", fin, 1);
    check("fin_done",  done,       1);
    check("fin_valid", addr_valid, 0);
    check("fin_busy",  busy,       0);
    check("fin_sent",  sent_cnt,   acc);
    m_sent = acc;
    @(negedge clk);
    check("idle_done",  done,       0);
    check("idle_valid", addr_valid, 0);
    check("idle_busy",  busy,       0);
    check("idle_sent",  sent_cnt,   m_sent);
  endtask

  initial begin
    int base, last, len, ab;
    rst_n      = 1'b0;
    cfg_base   = '0;
    cfg_last   = '0;
    cfg_len    = '0;
    start      = 1'b0;
    abort      = 1'b0;
    addr_ready = 1'b0;
`ifdef SONIC_ADDR_SEQ_PARITY_EN
    par_err_inject = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    run_seq(0, 8191, 1000, 0, -1, -1);
    run_seq(8190, 8191, 4, 0, -1, -1);
    run_seq(5, 5, 3, 0, -1, -1);
    run_seq(0, 8191, 3, 2, -1, -1);
    run_seq(0, 8191, 0, 0, -1, -1);
    run_seq(0, 8191, 100, 3, 10, -1);
    run_seq(0, 8191, 100, 0, 10, -1);
    run_seq(100, 50, 6, 0, -1, -1);
    run_seq(0, 8191, 200, 0, -1, 50);
    run_seq(7, 8191, 5, 0, -1, -1);

    for (int r = 0; r < 30; r++) begin
      base = int'($urandom_range(0, RING - 1));
      last = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, RING - 1))
                                         : int'($urandom_range(0, 15));
      len  = int'($urandom_range(0, 40));
      ab   = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_seq(base, last, len, 1, ab, -1);
    end
    run_seq(3, 9, 0, 1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
